// File: rtl/aurora_rx_gearbox_sync.sv
// Aurora 64b/66b receive gearbox: 20-bit words in, 66-bit blocks out.
// Hunts for sync-header alignment by bitslip; optional AURORA_RX_DESCRAMBLER_EN.
module aurora_rx_gearbox_sync #(
  parameter int LOCK_COUNT = 64,
  parameter int WINDOW     = 64,
  parameter int BAD_LIMIT  = 16
) (
  input  logic        Clk,
  input  logic        Rst_b,
  input  logic [19:0] Data20,
  input  logic        Data20Valid,
  output logic [65:0] Data66,
  output logic        Data66Valid,
  output logic        Locked,
  output logic        HeaderErr,
  output logic [7:0]  SlipCount
);

  typedef enum logic [1:0] {
    HUNT,
    SLIP_WAIT,
    LOCKED
  } state_t;

  state_t      state_q, state_d;
  logic [85:0] bits_q, bits_d;
  logic [6:0]  fill_q, fill_d;
  logic        pend_q, pend_d;
  logic [15:0] good_q, good_d;
  logic [15:0] win_q, win_d;
  logic [15:0] bad_q, bad_d;
  logic [7:0]  slip_q, slip_d;

  logic [85:0] ins;
  logic [85:0] comb_bits;
  logic [85:0] rem;
  logic [6:0]  tot;
  logic [6:0]  remfill;
  logic        emit;
  logic        hdr_ok;
  logic        slip;
  logic [65:0] blk;
  logic [63:0] pay;
  logic [15:0] win_n;
  logic [15:0] bad_n;

  // Append the new word behind the buffered bits; oldest bit sits at [85].
  // A pending slip drops the earliest bit of this word instead.
  always_comb begin
    ins       = pend_q ? {Data20[18:0], 67'b0} : {Data20, 66'b0};
    tot       = fill_q + (pend_q ? 7'd19 : 7'd20);
    comb_bits = bits_q | (ins >> fill_q);
    emit      = Data20Valid && (tot >= 7'd66);
    blk       = comb_bits[85:20];
    hdr_ok    = blk[65] ^ blk[64];
  end

  // Alignment FSM: counts headers per block and decides when to slip.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    win_d   = win_q;
    bad_d   = bad_q;
    slip_d  = slip_q;
    slip    = 1'b0;
    win_n   = win_q + 16'd1;
    bad_n   = bad_q + {15'd0, ~hdr_ok};
    if (emit) begin
      unique case (state_q)
        HUNT: begin
          if (hdr_ok) begin
            if (good_q + 16'd1 == 16'(LOCK_COUNT)) begin
              state_d = LOCKED;
              good_d  = '0;
              win_d   = '0;
              bad_d   = '0;
            end else begin
              good_d = good_q + 16'd1;
            end
          end else begin
            slip    = 1'b1;
            good_d  = '0;
            state_d = SLIP_WAIT;
            if (slip_q != 8'hFF) slip_d = slip_q + 8'd1;
          end
        end
        SLIP_WAIT: begin
          state_d = HUNT;
        end
        LOCKED: begin
          if (bad_n == 16'(BAD_LIMIT)) begin
            state_d = HUNT;
            good_d  = '0;
            win_d   = '0;
            bad_d   = '0;
          end else if (win_n == 16'(WINDOW)) begin
            win_d = '0;
            bad_d = '0;
          end else begin
            win_d = win_n;
            bad_d = bad_n;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // Remove the emitted block, then apply any slip to what is left.
  // With nothing left, the slip is deferred to the next accepted bit.
  always_comb begin
    bits_d  = bits_q;
    fill_d  = fill_q;
    pend_d  = pend_q;
    rem     = emit ? (comb_bits << 66) : comb_bits;
    remfill = emit ? (tot - 7'd66) : tot;
    if (Data20Valid) begin
      pend_d = 1'b0;
      if (slip) begin
        if (remfill != 7'd0) begin
          rem     = rem << 1;
          remfill = remfill - 7'd1;
        end else begin
          pend_d = 1'b1;
        end
      end
      bits_d = rem;
      fill_d = remfill;
    end
  end

`ifdef AURORA_RX_DESCRAMBLER_EN
  logic [57:0] hist_q, hist_d;
  logic [57:0] h;

  // Self-synchronizing x^58+x^39+1 descrambler, bit 0 first.
  always_comb begin
    h   = hist_q;
    pay = '0;
    for (int i = 0; i < 64; i++) begin
      pay[i] = blk[i] ^ h[38] ^ h[57];
      h      = {h[56:0], blk[i]};
    end
    hist_d = emit ? h : hist_q;
  end

  // History advances only on emitted blocks.
  always_ff @(posedge Clk or negedge Rst_b) begin
    if (!Rst_b) hist_q <= '0;
    else        hist_q <= hist_d;
  end
`else
  // Raw payload straight through.
  always_comb begin
    pay = blk[63:0];
  end
`endif

  // State, buffer and counter registers.
  always_ff @(posedge Clk or negedge Rst_b) begin
    if (!Rst_b) begin
      state_q <= HUNT;
      bits_q  <= '0;
      fill_q  <= '0;
      pend_q  <= 1'b0;
      good_q  <= '0;
      win_q   <= '0;
      bad_q   <= '0;
      slip_q  <= '0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      fill_q  <= fill_d;
      pend_q  <= pend_d;
      good_q  <= good_d;
      win_q   <= win_d;
      bad_q   <= bad_d;
      slip_q  <= slip_d;
    end
  end

  // Registered block output with its strobe and header-error pulse.
  always_ff @(posedge Clk or negedge Rst_b) begin
    if (!Rst_b) begin
      Data66      <= '0;
      Data66Valid <= 1'b0;
      HeaderErr   <= 1'b0;
    end else begin
      Data66Valid <= emit;
      HeaderErr   <= emit & ~hdr_ok;
      if (emit) Data66 <= {blk[65:64], pay};
    end
  end

  assign Locked    = (state_q == LOCKED);
  assign SlipCount = slip_q;

endmodule
